// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO.
// Sits on the CPU data-memory bus beside ram; data_out is zero unless this
// block is selected and being read, so the top level can OR it with ram_out.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-low
//   mem_addr   CPU byte address; window decoded on [31:4], register on [3:2]
//   memrd      read strobe
//   memwr      write strobe
//   data_in    CPU write data
//   data_out   combinational read data (0 when unselected or memrd=0)
//   sel        combinational window hit
//   tx         registered serial output, idle high
//   irq        registered, enable & fifo empty & ~busy (one-cycle lag)
//
// Register map (offset = mem_addr[3:2]):
//   0 TXDATA  write pushes data_in[7:0]; reads 0
//   1 STATUS  {16'h0, count[7:0], 4'h0, overflow, empty, full, busy}
//   2 CTRL    bit0 enable (R/W); writing bit1=1 clears overflow
//   3 -       reserved
//
// Serializer states:
//   state   | meaning
//   S_IDLE  | line high, waiting for enable & queued byte
//   S_START | start bit (tx=0) for CLKS_PER_BIT cycles
//   S_DATA  | 8 data bits LSB first, CLKS_PER_BIT cycles each
//   S_STOP  | stop bit (tx=1); chains straight into S_START if more data
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic        memrd,
  input  logic        memwr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        sel,
  output logic        tx,
  output logic        irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          irq_q, irq_d;
  logic          enable_q, enable_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic [1:0] offset;
  logic       wr_en, push, push_ok, pop, full, empty, busy, baud_done;
  logic       unused_bits;

  assign sel       = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign offset    = mem_addr[3:2];
  assign wr_en     = sel & memwr;
  assign push      = wr_en & (offset == 2'd0);
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign push_ok   = push & ~full;
  assign busy      = (state_q != S_IDLE);
  assign baud_done = (baud_q == '0);
  assign tx        = tx_q;
  assign irq       = irq_q;
  assign unused_bits = ^{mem_addr[1:0], data_in[31:8]};

  // Serializer next state; tx is derived from the next state so it is registered.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    if (busy && !baud_done) baud_d = baud_q - BW'(1);
    case (state_q)
      S_IDLE: begin
        if (enable_q && !empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rptr_q];
          baud_d  = BAUD_LOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d    = BAUD_LOAD;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = BAUD_LOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d = BAUD_LOAD;
          if (enable_q && !empty) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO bookkeeping and control register; full is pre-edge, so a push while
  // full is dropped even when a pop happens on the same edge.
  always_comb begin
    rptr_d   = rptr_q + PW'(pop);
    wptr_d   = wptr_q + PW'(push_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    enable_d = enable_q;
    ovf_d    = ovf_q;
    if (push && full) ovf_d = 1'b1;
    if (wr_en && offset == 2'd2) begin
      enable_d = data_in[0];
      if (data_in[1]) ovf_d = 1'b0;
    end
    irq_d = enable_q & empty & ~busy;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      irq_q     <= 1'b0;
      enable_q  <= 1'b1;
      ovf_q     <= 1'b0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      irq_q     <= irq_d;
      enable_q  <= enable_d;
      ovf_q     <= ovf_d;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (reset && push_ok) fifo_mem[wptr_q] <= data_in[7:0];
  end

  always_comb begin
    data_out = '0;
    if (sel && memrd) begin
      case (offset)
        2'd1:    data_out = {16'h0, 8'(count_q), 4'h0, ovf_q, empty, full, busy};
        2'd2:    data_out = {31'h0, enable_q};
        default: data_out = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam int C = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] mem_addr = '0;
  logic memrd = 1'b0;
  logic memwr = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic sel, tx, irq;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .memrd(memrd), .memwr(memwr),
    .data_in(data_in), .data_out(data_out), .sel(sel), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: byte queue + frame position ----------
  logic [7:0] mq[$];
  bit m_en, m_ovf, m_irq, m_active;
  int m_pos;
  logic [7:0] m_byte;

  always @(posedge clk) begin : model
    int n;
    bit m_full, m_empty, fend, pop, nirq, hit;
    if (!reset) begin
      mq.delete();
      m_en = 1'b1; m_ovf = 1'b0; m_irq = 1'b0; m_active = 1'b0; m_pos = 0; m_byte = '0;
    end else begin
      n = mq.size();
      m_full = (n == DEPTH);
      m_empty = (n == 0);
      nirq = m_en && m_empty && !m_active;
      fend = m_active && (m_pos == 10 * C - 1);
      pop = m_en && !m_empty && (!m_active || fend);
      if (m_active && !fend) m_pos++;
      else if (pop) begin m_byte = mq.pop_front(); m_active = 1'b1; m_pos = 0; end
      else m_active = 1'b0;
      hit = (mem_addr[31:4] == BASE[31:4]) && memwr;
      if (hit && mem_addr[3:2] == 2'd0) begin
        if (m_full) m_ovf = 1'b1;
        else mq.push_back(data_in[7:0]);
      end
      if (hit && mem_addr[3:2] == 2'd2) begin
        m_en = data_in[0];
        if (data_in[1]) m_ovf = 1'b0;
      end
      m_irq = nirq;
    end
  end

  function automatic logic exp_tx();
    if (!m_active) return 1'b1;
    if (m_pos < C) return 1'b0;
    if (m_pos < 9 * C) return m_byte[(m_pos - C) / C];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_dout();
    int n = mq.size();
    logic e, f;
    e = (n == 0);
    f = (n == DEPTH);
    if (!(memrd && mem_addr[31:4] == BASE[31:4])) return 32'h0;
    case (mem_addr[3:2])
      2'd1: return {16'h0, 8'(n), 4'h0, m_ovf, e, f, m_active};
      2'd2: return {31'h0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx", tx, exp_tx());
      check("irq", irq, m_irq);
      check("sel", sel, mem_addr[31:4] == BASE[31:4]);
      check("data_out", data_out, exp_dout());
    end
  end

  // ---------------- independent line receiver ----------
  logic [7:0] rx_q[$];
  int rx_ferr = 0;
  bit rx_busy = 1'b0;
  int rx_cnt = 0;
  logic [7:0] rx_sh = '0;

  always @(negedge clk) begin
    if (!reset) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (tx === 1'b0) begin rx_busy = 1'b1; rx_cnt = 0; end
    end else begin
      rx_cnt++;
      if (rx_cnt % C == C / 2 && rx_cnt / C >= 1 && rx_cnt / C <= 8)
        rx_sh[rx_cnt / C - 1] = tx;
      if (rx_cnt == 9 * C + C / 2) begin
        if (tx === 1'b1) rx_q.push_back(rx_sh);
        else rx_ferr++;
        rx_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_addr = a; data_in = d; memwr = 1'b1;
    tick();
    memwr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    mem_addr = a; memrd = 1'b1;
    @(negedge clk);
    d = data_out;
    tick();
    memrd = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((m_active || mq.size() != 0) && k < budget) begin tick(); k++; end
    check("drain_within_budget", k < budget, 1'b1);
    repeat (4) tick();
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, rx_q.size(), exp.size());
    for (int i = 0; i < rx_q.size() && i < exp.size(); i++)
      check($sformatf("%s_byte%0d", name, i), rx_q[i], exp[i]);
  endtask

  initial begin
    logic [31:0] d;
    logic [9:0] bits;
    logic [7:0] exp[$];

    repeat (3) tick();
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_irq", irq, 1'b0);
    tick();
    reset = 1'b1;
    rd(BASE + 4, d);  check("reset_status", d, 32'h4);
    rd(BASE + 8, d);  check("reset_ctrl", d, 32'h1);

    // Single byte 0xA5, sampled mid-bit.
    rx_q.delete();
    wr(BASE, 32'hA5);
    bits = {1'b1, 8'hA5, 1'b0};
    repeat (3) tick();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("a5_bit%0d", k), tx, bits[k]);
      repeat (C) tick();
    end
    @(negedge clk);
    check("a5_irq_after_frame", irq, 1'b1);
    exp = '{8'hA5};
    check_rx("a5_rx", exp);

    // Back-to-back frames.
    rx_q.delete();
    wr(BASE, 32'h00); wr(BASE, 32'hFF); wr(BASE, 32'h55);
    rd(BASE + 4, d);  check("b2b_status_after_writes", d, 32'h0000_0201);
    repeat (37) tick();
    @(negedge clk);   check("b2b_stop1_last", tx, 1'b1);
    tick();
    @(negedge clk);   check("b2b_start2_first", tx, 1'b0);
    repeat (79) tick();
    rd(BASE + 4, d);  check("b2b_busy_cycle119", d, 32'h5);
    rd(BASE + 4, d);  check("b2b_idle_cycle120", d, 32'h4);
    wait_idle(100);
    exp = '{8'h00, 8'hFF, 8'h55};
    check_rx("b2b_rx", exp);

    // Overflow with the serializer disabled.
    rx_q.delete();
    wr(BASE + 8, 32'h0);
    for (int i = 0; i < 9; i++) wr(BASE, 32'h10 + i);
    rd(BASE + 4, d);  check("ovf_status", d, 32'h0000_080A);
    @(negedge clk);   check("ovf_irq_disabled", irq, 1'b0);
    tick();
    wr(BASE + 8, 32'h3);
    rd(BASE + 4, d);  check("ovf_cleared_status", d, 32'h0000_0802);
    wait_idle(8 * 10 * C + 50);
    exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    check_rx("ovf_rx", exp);

    // Decode isolation.
    mem_addr = BASE + 32'h10; data_in = 32'h99; memwr = 1'b1; memrd = 1'b1;
    @(negedge clk);
    check("iso_hi_sel", sel, 1'b0);
    check("iso_hi_dout", data_out, 32'h0);
    tick();
    mem_addr = BASE - 32'h4;
    @(negedge clk);
    check("iso_lo_sel", sel, 1'b0);
    check("iso_lo_dout", data_out, 32'h0);
    tick();
    memwr = 1'b0; memrd = 1'b0;
    rd(BASE + 5, d);   check("iso_status_lowbits", d, 32'h4);
    rd(BASE + 12, d);  check("iso_reserved", d, 32'h0);
    mem_addr = BASE + 8; data_in = 32'h0; memwr = 1'b1; memrd = 1'b1;
    @(negedge clk);
    check("rdwr_ctrl_preedge", data_out, 32'h1);
    tick();
    memwr = 1'b0; memrd = 1'b0;
    rd(BASE + 8, d);   check("rdwr_ctrl_after", d, 32'h0);
    wr(BASE + 8, 32'h1);

    // Enable dropped mid-frame.
    rx_q.delete();
    wr(BASE, 32'h3C); wr(BASE, 32'hC3);
    repeat (10) tick();
    wr(BASE + 8, 32'h0);
    repeat (60) tick();
    rd(BASE + 4, d);   check("endrop_status", d, 32'h0000_0100);
    @(negedge clk);    check("endrop_tx_high", tx, 1'b1);
    tick();
    exp = '{8'h3C};
    check_rx("endrop_rx", exp);
    wr(BASE + 8, 32'h1);
    wait_idle(100);
    exp = '{8'h3C, 8'hC3};
    check_rx("reen_rx", exp);

    // Reset mid-frame.
    wr(BASE, 32'h00); wr(BASE, 32'h66);
    repeat (15) tick();
    @(negedge clk);    check("rst_tx_low_before", tx, 1'b0);
    reset = 1'b0;
    tick();
    @(negedge clk);    check("rst_tx_high", tx, 1'b1);
    tick();
    reset = 1'b1;
    rd(BASE + 4, d);   check("rst_status", d, 32'h4);
    rd(BASE + 8, d);   check("rst_ctrl", d, 32'h1);

    // Randomized traffic, checked every cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      int sel_a;
      sel_a = $urandom_range(0, 9);
      if (sel_a <= 6)      mem_addr = BASE + $urandom_range(0, 15);
      else if (sel_a == 7) mem_addr = BASE + 32'h10 + $urandom_range(0, 15);
      else if (sel_a == 8) mem_addr = BASE - 32'h4;
      else                 mem_addr = $urandom;
      data_in = $urandom;
      memrd = 1'($urandom_range(0, 1));
      memwr = ($urandom_range(0, 99) < 30);
      if (mem_addr[3:2] == 2'd2) data_in[0] = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 599) != 0);
      tick();
    end
    memwr = 1'b0; memrd = 1'b0; reset = 1'b1;
    wr(BASE + 8, 32'h1);
    wait_idle(DEPTH * 10 * C + 100);
    check("rx_framing_errors", rx_ferr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that responds on the CPU data-memory bus (the `mem_addr`/`memrd`/`memwr` interface the CPU drives toward `ram`). Firmware writes bytes into an internal FIFO, and the block serializes them 8N1 on `tx`. It sits beside `ram` in `computer`. Its `data_out` is zero when the block is not selected, so the top level can OR it with `ram_out` onto the CPU read-data input.

## Interface
Parameters:
- `BASE_ADDR`, 32'hFFFF_FF00: 16-byte-aligned base of the register window.
- `CLKS_PER_BIT`, 16: clocks per serial bit; ≥2.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `mem_addr` in 32: byte address from the CPU.
- `memrd` in 1: read strobe.
- `memwr` in 1: write strobe.
- `data_in` in 32: write data from the CPU (`data_mem_out`).
- `data_out` out 32: read data to the CPU. Combinational. 0 when not selected or when `memrd`=0.
- `sel` out 1: combinational, 1 when `mem_addr[31:4]==BASE_ADDR[31:4]`.
- `tx` out 1: serial output; registered; idle high.
- `irq` out 1: registered; equals `enable & fifo_empty & ~busy`.

## Operation
- Register decode uses offset `mem_addr[3:2]`; `mem_addr[1:0]` are ignored.
  - 0 TXDATA: write pushes `data_in[7:0]`; read returns 0.
  - 1 STATUS, read-only: bit0 busy, bit1 full, bit2 empty, bit3 overflow (sticky), bits[15:8] FIFO count. All other bits are 0.
  - 2 CTRL: bit0 enable is R/W. Writing bit1=1 clears overflow (bit1 reads 0).
  - 3: reserved; reads 0, writes ignored.
- Writes take effect on the clock edge where `sel & memwr`.
- If `memrd` and `memwr` are both high, the read returns pre-edge values.
- FIFO:
  - Circular buffer with read/write pointers and a count of width clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - A push while full drops the byte and sets overflow.
  - Full is evaluated on pre-edge state. A push and a pop in the same cycle while full: the pop occurs, the push is dropped, and overflow is set.
  - A push and a pop in the same cycle while not full: both occur and the count is unchanged.
- Serializer FSM, states IDLE, START, DATA, STOP:
  - IDLE: if `enable` & !empty, pop into an 8-bit shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: shift out 8 bits LSB first, each CLKS_PER_BIT cycles, with a 3-bit bit index; then STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the end, if `enable` & !empty, pop and go directly to START (no idle gap); else go to IDLE.
  - Baud counter: loads CLKS_PER_BIT-1 on each state or bit entry, decrements, and advances at 0.
- Clearing `enable` mid-frame does not abort: the current frame completes and no new pop occurs.
- busy = (state != IDLE).
- Reset values: `tx`=1, state IDLE, FIFO empty (pointers and count 0), overflow 0, enable 1, `irq`=0 on the cycle after reset (then it follows its equation), shift register 0.
- Reset asserted mid-frame: `tx` returns to 1 at the next edge, and FIFO contents are discarded.

## Timing
- TXDATA write captured at edge N (count=1).
- If IDLE and enabled, edge N+1 pops and `tx` goes 0 after N+1. Write-to-start-bit latency is 2 edges.
- A frame occupies exactly 10·CLKS_PER_BIT cycles of `tx`. Back-to-back frames have no idle cycles between the stop bit and the next start bit.
- A STATUS read during the cycle of the write edge shows pre-write values; it shows the updated values from the following cycle.
- `irq` lags its inputs by one cycle.

## Test plan
- Reset then single byte: write 0xA5 to BASE_ADDR; with CLKS_PER_BIT=4, `tx` goes low 2 edges later. Sampling mid-bit must give 0, then 1,0,1,0,0,1,0,1, then stop=1. `irq` is 1 after 40+ cycles.
- Back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles → three contiguous frames, 120 cycles total at CLKS_PER_BIT=4, with no gap. STATUS count reads 2 immediately after the third write.
- Overflow: disable via CTRL=0, push 9 bytes with FIFO_DEPTH=8 → STATUS = full|overflow, count 8. Write CTRL=0x3 → overflow clears, the 8 bytes transmit in order, and the 9th byte is never sent.
- Decode isolation: accesses at BASE_ADDR+0x10 and BASE_ADDR-4 → `sel`=0, `data_out`=0, FIFO unchanged. A reserved offset 0xC reads 0.
- Enable drop mid-frame: clear enable during DATA with 2 bytes queued → the current frame finishes, `tx` stays 1, count stays 1. Re-enable → the remaining byte is sent.
- Reset mid-frame: pull `reset` low during DATA → `tx`=1 at the next edge, STATUS=0x04 (empty), and CTRL reads 1.
